// File: rtl/ef_tmr32_pkg.sv
// Shared constants and types for the ef_tmr32 multi-channel timer.
// Mode/clock-source/capture encodings match the register fields seen by the bus wrapper.
package ef_tmr32_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_UPDOWN = 2'd2;

  localparam logic CLK_SRC_PRE = 1'b0;
  localparam logic CLK_SRC_EXT = 1'b1;

  localparam int CP_RISE = 0;
  localparam int CP_FALL = 1;

  typedef enum logic [1:0] {
    CNT_UP,
    CNT_DOWN,
    CNT_UPDOWN
  } cnt_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Encoding 3 is reserved and behaves as plain up counting.
  function automatic cnt_mode_e decode_mode(input logic [1:0] m);
    case (m)
      MODE_DOWN:   return CNT_DOWN;
      MODE_UPDOWN: return CNT_UPDOWN;
      default:     return CNT_UP;
    endcase
  endfunction

endpackage

// File: rtl/ef_tmr32_cmp_ch.sv
// One compare channel: match detection on the value being loaded into the counter,
// PWM set/clear state and output polarity. Match and PWM outputs are registered.
module ef_tmr32_cmp_ch
  import ef_tmr32_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_adv,
  input  logic [W-1:0] i_new,
  input  logic [W-1:0] i_cmp,
  input  logic         i_term,
  input  logic         i_updown,
  input  logic         i_step_down,
  input  logic         i_pwm_en,
  input  logic         i_pwm_inv,
  output logic         o_match,
  output logic         o_pwm
);

  logic w_hit;
  logic w_raw_next;
  logic r_raw;
  logic r_pwm;
  logic r_match;

  assign w_hit = i_adv & (i_new == i_cmp);

  // In up-down mode the step direction decides set vs clear; otherwise a match wins over terminal.
  always_comb begin
    w_raw_next = r_raw;
    if (!i_pwm_en) begin
      w_raw_next = 1'b0;
    end else if (i_adv) begin
      if (i_updown) begin
        if (w_hit) w_raw_next = ~i_step_down;
      end else if (w_hit) begin
        w_raw_next = 1'b1;
      end else if (i_term) begin
        w_raw_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw   <= 1'b0;
      r_pwm   <= 1'b0;
      r_match <= 1'b0;
    end else if (i_en) begin
      r_raw   <= w_raw_next;
      r_pwm   <= w_raw_next ^ i_pwm_inv;
      r_match <= w_hit;
    end else begin
      r_match <= 1'b0;
    end
  end

  assign o_match = r_match;
  assign o_pwm   = r_pwm;

endmodule

// File: rtl/ef_tmr32_mc.sv
// General-purpose timer: prescaled or external-clocked counter (up/down/center-aligned),
// N_CMP PWM compare channels and a synchronised timestamp capture input.
module ef_tmr32_mc
  import ef_tmr32_pkg::*;
#(
  parameter int W     = 32,
  parameter int N_CMP = 4,
  parameter int PRE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               tmr_en,
  input  logic [1:0]         mode,
  input  logic               one_shot,
  input  logic               clk_src,
  input  logic [PRE_W-1:0]   pre_div,
  input  logic [W-1:0]       period,
  input  logic [N_CMP*W-1:0] cmp,
  input  logic [N_CMP-1:0]   pwm_en,
  input  logic [N_CMP-1:0]   pwm_inv,
  input  logic               ext_in,
  input  logic               cp_en,
  input  logic [1:0]         cp_event,
  output logic [W-1:0]       tmr,
  output logic [W-1:0]       cp_value,
  output logic [N_CMP-1:0]   pwm_out,
  output logic               to_flag,
  output logic [N_CMP-1:0]   match_flag,
  output logic               cp_flag
);

  localparam logic [W-1:0] ONE = W'(1);

  logic             r_sync1, r_sync2, r_sync3;
  logic             w_rise, w_fall;
  logic [PRE_W-1:0] r_pre;
  logic             w_pre_tick, w_tick, w_adv;
  cnt_mode_e        w_mode;
  logic [W-1:0]     r_tmr, w_next, w_reload, w_new;
  dir_e             r_dir, w_dir_next, w_dir_new;
  logic             w_term, w_reload_now;
  logic             r_stop, r_to;
  logic             w_cp_hit;
  logic             r_cp_flag;
  logic [W-1:0]     r_cp_val;
  logic [N_CMP-1:0] w_match, w_pwm;

  // The pin synchroniser keeps running while the block is disabled so edges are never stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ext_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_fall = ~r_sync2 & r_sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (!en || !tmr_en || (r_pre == pre_div)) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_pre_tick = (r_pre == pre_div);
  assign w_tick     = (clk_src == CLK_SRC_EXT) ? w_rise : w_pre_tick;
  assign w_adv      = en & tmr_en & w_tick & ~r_stop;
  assign w_mode     = decode_mode(mode);

  // Next count and direction for one tick; a one-shot terminal replaces it with the reload value.
  always_comb begin
    w_next     = r_tmr;
    w_term     = 1'b0;
    w_dir_next = r_dir;
    case (w_mode)
      CNT_DOWN: begin
        if (r_tmr == '0) begin
          w_next = period;
          w_term = 1'b1;
        end else begin
          w_next = r_tmr - ONE;
        end
      end
      CNT_UPDOWN: begin
        if (period == '0) begin
          w_next = '0;
          w_term = 1'b1;
        end else if (r_dir == DIR_UP) begin
          if (r_tmr == period) begin
            w_next     = period - ONE;
            w_dir_next = DIR_DOWN;
          end else begin
            w_next = r_tmr + ONE;
          end
        end else begin
          if (r_tmr == '0) begin
            w_next     = ONE;
            w_dir_next = DIR_UP;
            w_term     = 1'b1;
          end else begin
            w_next = r_tmr - ONE;
          end
        end
      end
      default: begin
        if (r_tmr == period) begin
          w_next = '0;
          w_term = 1'b1;
        end else begin
          w_next = r_tmr + ONE;
        end
      end
    endcase
  end

  assign w_reload     = (w_mode == CNT_DOWN) ? period : '0;
  assign w_reload_now = w_term & one_shot;
  assign w_new        = w_reload_now ? w_reload : w_next;
  assign w_dir_new    = w_reload_now ? DIR_UP : w_dir_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr  <= '0;
      r_dir  <= DIR_UP;
      r_stop <= 1'b0;
      r_to   <= 1'b0;
    end else if (!en) begin
      r_to <= 1'b0;
    end else if (!tmr_en) begin
      r_tmr  <= w_reload;
      r_dir  <= DIR_UP;
      r_stop <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_to <= w_adv & w_term;
      if (w_adv) begin
        r_tmr <= w_new;
        r_dir <= w_dir_new;
        if (w_reload_now) r_stop <= 1'b1;
      end
    end
  end

  assign w_cp_hit = cp_en & ((cp_event[CP_RISE] & w_rise) | (cp_event[CP_FALL] & w_fall));

  // Capture stores the count as it stands before this edge's tick is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cp_val  <= '0;
      r_cp_flag <= 1'b0;
    end else if (en) begin
      r_cp_flag <= w_cp_hit;
      if (w_cp_hit) r_cp_val <= r_tmr;
    end else begin
      r_cp_flag <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CMP; g++) begin : g_ch
    ef_tmr32_cmp_ch #(.W(W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_en       (en),
      .i_adv      (w_adv),
      .i_new      (w_new),
      .i_cmp      (cmp[g*W +: W]),
      .i_term     (w_term),
      .i_updown   (w_mode == CNT_UPDOWN),
      .i_step_down(w_dir_new == DIR_DOWN),
      .i_pwm_en   (pwm_en[g]),
      .i_pwm_inv  (pwm_inv[g]),
      .o_match    (w_match[g]),
      .o_pwm      (w_pwm[g])
    );
  end

  assign tmr        = r_tmr;
  assign cp_value   = r_cp_val;
  assign pwm_out    = w_pwm;
  assign to_flag    = r_to;
  assign match_flag = w_match;
  assign cp_flag    = r_cp_flag;

endmodule
